// File: rtl/cw341_reg_bus_arbiter_if.sv
// cw341_reg_bus_arbiter_if: bundles the USB master, internal master and shared register bus of the arbiter
// Signal groups:
//   usb_*     USB register master: busy/hold hints, address, byte count, write data, strobes, returned read data
//   int_*     internal single-beat master: req/we/address/bytecnt/wdata in, ack pulse and captured rdata out
//   reg_*     shared register bus driven towards the register blocks, reg_datai returned by them
//   abort_cnt, collision, collision_clr   status counters/flags and the flag clear
// Modport master is the arbiter's view; modport slave is the environment's view.
interface cw341_reg_bus_arbiter_if #(
    parameter int pBYTECNT_SIZE = 7
);
    logic                     usb_busy;
    logic                     usb_hold;
    logic [7:0]               usb_address;
    logic [pBYTECNT_SIZE-1:0] usb_bytecnt;
    logic [7:0]               usb_datao;
    logic                     usb_read;
    logic                     usb_write;
    logic [7:0]               usb_datai;
    logic                     int_req;
    logic                     int_we;
    logic [7:0]               int_address;
    logic [pBYTECNT_SIZE-1:0] int_bytecnt;
    logic [7:0]               int_wdata;
    logic                     int_ack;
    logic [7:0]               int_rdata;
    logic [7:0]               reg_address;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
    logic [7:0]               reg_datao;
    logic                     reg_read;
    logic                     reg_write;
    logic [7:0]               reg_datai;
    logic [7:0]               abort_cnt;
    logic                     collision;
    logic                     collision_clr;

    modport master (
        input  usb_busy, usb_hold, usb_address, usb_bytecnt, usb_datao, usb_read, usb_write,
        input  int_req, int_we, int_address, int_bytecnt, int_wdata, reg_datai, collision_clr,
        output usb_datai, int_ack, int_rdata, reg_address, reg_bytecnt, reg_datao, reg_read, reg_write,
        output abort_cnt, collision
    );

    modport slave (
        output usb_busy, usb_hold, usb_address, usb_bytecnt, usb_datao, usb_read, usb_write,
        output int_req, int_we, int_address, int_bytecnt, int_wdata, reg_datai, collision_clr,
        input  usb_datai, int_ack, int_rdata, reg_address, reg_bytecnt, reg_datao, reg_read, reg_write,
        input  abort_cnt, collision
    );
endinterface

// File: rtl/cw341_reg_bus_arbiter.sv
// cw341_reg_bus_arbiter: shares the register bus between the USB master (priority) and an internal master
// Ports:
//   clk_usb   clock for all logic
//   reset_n   asynchronous active-low reset
//   bus       cw341_reg_bus_arbiter_if.master: USB master, internal master, shared reg_* bus, status
// The USB master passes straight through whenever it owns the bus; the internal master is only
// granted after pGUARD quiet cycles and runs a fixed ADDR -> STROBE -> CAPTURE access.
module cw341_reg_bus_arbiter #(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pGUARD        = 4
) (
    input  logic                   clk_usb,
    input  logic                   reset_n,
    cw341_reg_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, STROBE, CAPTURE} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               guard_q, guard_d;
    logic [7:0]               addr_q, wdata_q, rdata_q, rdata_d, abort_q, abort_d;
    logic [pBYTECNT_SIZE-1:0] cnt_q;
    logic                     we_q, coll_q, coll_d;
    logic                     quiet, usb_strobe, hit, grant, abort;
    logic                     int_own, int_rd, int_wr, ack;

    assign quiet      = !bus.usb_busy && !bus.usb_hold;
    assign usb_strobe = bus.usb_read || bus.usb_write;
    // A USB strobe during an internal access takes the bus for that cycle.
    assign hit        = state_q != IDLE && usb_strobe;
    assign grant      = state_q == IDLE && bus.int_req && guard_q == 4'(pGUARD) && quiet && !usb_strobe;
    // An access is dropped if it loses the bus before its strobe reached the register blocks.
    assign abort      = (state_q == ADDR && (bus.usb_busy || hit)) || (state_q == STROBE && hit);

    assign guard_d = !quiet ? 4'd0 : (guard_q == 4'(pGUARD) ? guard_q : guard_q + 4'd1);
    assign rdata_d = (ack && !we_q) ? bus.reg_datai : rdata_q;
    assign abort_d = (abort && abort_q != 8'hFF) ? abort_q + 8'd1 : abort_q;
    assign coll_d  = hit ? 1'b1 : (bus.collision_clr ? 1'b0 : coll_q);

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = ADDR;
            ADDR:    state_d = abort ? IDLE : STROBE;
            STROBE:  state_d = abort ? IDLE : CAPTURE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        int_own = state_q != IDLE && !hit;
        int_rd  = state_q == STROBE && !we_q;
        int_wr  = state_q == STROBE && we_q;
        ack     = state_q == CAPTURE;
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            guard_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            abort_q <= '0;
            coll_q  <= 1'b0;
        end else begin
            guard_q <= guard_d;
            rdata_q <= rdata_d;
            abort_q <= abort_d;
            coll_q  <= coll_d;
            if (grant) begin
                addr_q  <= bus.int_address;
                cnt_q   <= bus.int_bytecnt;
                wdata_q <= bus.int_wdata;
                we_q    <= bus.int_we;
            end
        end
    end

    assign bus.reg_address = int_own ? addr_q  : bus.usb_address;
    assign bus.reg_bytecnt = int_own ? cnt_q   : bus.usb_bytecnt;
    assign bus.reg_datao   = int_own ? wdata_q : bus.usb_datao;
    assign bus.reg_read    = int_own ? int_rd  : bus.usb_read;
    assign bus.reg_write   = int_own ? int_wr  : bus.usb_write;
    assign bus.usb_datai   = bus.reg_datai;
    assign bus.int_ack     = ack;
    // Read data is visible in the ack cycle itself, then held from the register.
    assign bus.int_rdata   = rdata_d;
    assign bus.abort_cnt   = abort_q;
    assign bus.collision   = coll_q;
endmodule

// File: tb/tb_cw341_reg_bus_arbiter.sv
// tb_cw341_reg_bus_arbiter: vector table, directed corner sequences and random traffic against a reference model
module tb_cw341_reg_bus_arbiter;
    localparam int G = 4;

    logic clk_usb = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk_usb = ~clk_usb;

    cw341_reg_bus_arbiter_if #(.pBYTECNT_SIZE(7)) bus ();
    cw341_reg_bus_arbiter #(.pBYTECNT_SIZE(7), .pGUARD(G)) dut (
        .clk_usb(clk_usb),
        .reset_n(reset_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: an access is "since" cycles old (-1 = none); quiet counts unbroken idle USB cycles.
    int         since = -1;
    int         quiet = 0;
    int         abort_m = 0;
    bit         coll_m = 1'b0;
    logic [7:0] held_m = 8'h00;
    logic [7:0] la_addr = 8'h00;
    logic [7:0] la_wd = 8'h00;
    logic [6:0] la_cnt = 7'h00;
    bit         la_we = 1'b0;
    logic       d_ack = 1'b0;
    int         wr_seen = 0;

    typedef struct {
        bit busy, rd, wr;
        logic [7:0] addr, dato, dati;
        logic [7:0] x_addr, x_dato, x_dati;
        bit x_rd, x_wr, x_ack;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mreset();
        since = -1;
        quiet = 0;
        abort_m = 0;
        coll_m = 1'b0;
        held_m = 8'h00;
    endtask

    task automatic probe();
        bit act, coll, drive;
        if (!reset_n) mreset();
        act = since >= 0;
        coll = act && (bus.usb_read || bus.usb_write);
        drive = act && !coll;
        #1;
        chk("reg_address", bus.reg_address, drive ? la_addr : bus.usb_address);
        chk("reg_bytecnt", {1'b0, bus.reg_bytecnt}, {1'b0, drive ? la_cnt : bus.usb_bytecnt});
        chk("reg_datao", bus.reg_datao, drive ? la_wd : bus.usb_datao);
        chk1("reg_read", bus.reg_read, drive ? (since == 1 && !la_we) : bus.usb_read);
        chk1("reg_write", bus.reg_write, drive ? (since == 1 && la_we) : bus.usb_write);
        chk("usb_datai", bus.usb_datai, bus.reg_datai);
        chk1("int_ack", bus.int_ack, since == 2);
        chk("int_rdata", bus.int_rdata, (since == 2 && !la_we) ? bus.reg_datai : held_m);
        chk("abort_cnt", bus.abort_cnt, 8'(abort_m));
        chk1("collision", bus.collision, coll_m);
        d_ack = bus.int_ack;
        if (bus.reg_write && !bus.usb_write) wr_seen++;
    endtask

    task automatic tick();
        bit act, coll, busy, gr;
        act = since >= 0;
        busy = bus.usb_busy;
        coll = act && (bus.usb_read || bus.usb_write);
        gr = !act && bus.int_req && quiet >= G && !busy && !bus.usb_hold && !(bus.usb_read || bus.usb_write);
        @(posedge clk_usb);
        if (!reset_n) mreset();
        else begin
            quiet = (busy || bus.usb_hold) ? 0 : (quiet < 1000 ? quiet + 1 : quiet);
            if ((since == 0 && (busy || coll)) || (since == 1 && coll)) begin
                since = -1;
                if (abort_m < 255) abort_m++;
            end else if (since == 2) begin
                since = -1;
                if (!la_we) held_m = bus.reg_datai;
            end else if (since >= 0) since++;
            else if (gr) begin
                since = 0;
                la_addr = bus.int_address;
                la_cnt = bus.int_bytecnt;
                la_wd = bus.int_wdata;
                la_we = bus.int_we;
            end
            if (coll) coll_m = 1'b1;
            else if (bus.collision_clr) coll_m = 1'b0;
        end
        @(negedge clk_usb);
    endtask

    task automatic cyc();
        probe();
        tick();
    endtask

    task automatic usb_idle();
        bus.usb_busy = 1'b0;
        bus.usb_hold = 1'b0;
        bus.usb_address = 8'h00;
        bus.usb_bytecnt = 7'h00;
        bus.usb_datao = 8'h00;
        bus.usb_read = 1'b0;
        bus.usb_write = 1'b0;
    endtask

    task automatic int_set(bit we, logic [7:0] a, logic [7:0] d);
        bus.int_req = 1'b1;
        bus.int_we = we;
        bus.int_address = a;
        bus.int_bytecnt = 7'h03;
        bus.int_wdata = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, n, age, busy_left;
        tbl[0]  = '{1, 1, 0, 8'h01, 8'h10, 8'hA0, 8'h01, 8'h10, 8'hA0, 1, 0, 0};
        tbl[1]  = '{0, 0, 0, 8'h02, 8'h20, 8'hA1, 8'h02, 8'h20, 8'hA1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 8'h03, 8'h30, 8'hA2, 8'h03, 8'h30, 8'hA2, 0, 0, 0};
        tbl[3]  = '{1, 0, 1, 8'h04, 8'h40, 8'hA3, 8'h04, 8'h40, 8'hA3, 0, 1, 0};
        tbl[4]  = '{0, 0, 0, 8'h05, 8'h50, 8'hA4, 8'h05, 8'h50, 8'hA4, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 8'h06, 8'h60, 8'hA5, 8'h06, 8'h60, 8'hA5, 0, 0, 0};
        tbl[6]  = '{1, 1, 0, 8'h07, 8'h70, 8'hA6, 8'h07, 8'h70, 8'hA6, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 8'h08, 8'h80, 8'hA7, 8'h08, 8'h80, 8'hA7, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 8'h09, 8'h90, 8'hA8, 8'h09, 8'h90, 8'hA8, 0, 0, 0};
        tbl[9]  = '{1, 0, 1, 8'h0A, 8'hA0, 8'hA9, 8'h0A, 8'hA0, 8'hA9, 0, 1, 0};
        tbl[10] = '{0, 0, 0, 8'h0B, 8'hB0, 8'hAA, 8'h0B, 8'hB0, 8'hAA, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 8'h0C, 8'hC0, 8'hAB, 8'h0C, 8'hC0, 8'hAB, 0, 0, 0};

        usb_idle();
        bus.int_req = 1'b0;
        bus.int_we = 1'b0;
        bus.int_address = 8'h00;
        bus.int_bytecnt = 7'h00;
        bus.int_wdata = 8'h00;
        bus.reg_datai = 8'h00;
        bus.collision_clr = 1'b0;
        #1 reset_n = 1'b0;
        @(negedge clk_usb);

        // Reset state
        probe();
        chk("rst_reg_address", bus.reg_address, 8'h00);
        chk("rst_reg_datao", bus.reg_datao, 8'h00);
        chk1("rst_reg_read", bus.reg_read, 1'b0);
        chk1("rst_reg_write", bus.reg_write, 1'b0);
        chk1("rst_int_ack", bus.int_ack, 1'b0);
        chk("rst_int_rdata", bus.int_rdata, 8'h00);
        chk("rst_abort_cnt", bus.abort_cnt, 8'h00);
        chk1("rst_collision", bus.collision, 1'b0);
        tick();
        reset_n = 1'b1;

        // Pass-through with busy pulsing every 3 cycles: pending request must never be granted
        int_set(1'b1, 8'hEE, 8'h77);
        for (int i = 0; i < 12; i++) begin
            bus.usb_busy = tbl[i].busy;
            bus.usb_read = tbl[i].rd;
            bus.usb_write = tbl[i].wr;
            bus.usb_address = tbl[i].addr;
            bus.usb_datao = tbl[i].dato;
            bus.reg_datai = tbl[i].dati;
            probe();
            chk("tbl_reg_address", bus.reg_address, tbl[i].x_addr);
            chk("tbl_reg_datao", bus.reg_datao, tbl[i].x_dato);
            chk("tbl_usb_datai", bus.usb_datai, tbl[i].x_dati);
            chk1("tbl_reg_read", bus.reg_read, tbl[i].x_rd);
            chk1("tbl_reg_write", bus.reg_write, tbl[i].x_wr);
            chk1("tbl_int_ack", bus.int_ack, tbl[i].x_ack);
            tick();
        end

        // Guard: one busy cycle, then grant in the 5th quiet cycle, ADDR in the 6th
        usb_idle();
        bus.usb_busy = 1'b1;
        cyc();
        bus.usb_busy = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            probe();
            if (k <= 5) chk("guard_wait_addr", bus.reg_address, 8'h00);
            if (k == 6) chk("guard_addr", bus.reg_address, 8'hEE);
            if (k == 6) chk1("guard_addr_nostrobe", bus.reg_write, 1'b0);
            if (k == 7) chk1("guard_strobe", bus.reg_write, 1'b1);
            if (k == 7) chk("guard_wdata", bus.reg_datao, 8'h77);
            if (k == 8) chk1("guard_ack", bus.int_ack, 1'b1);
            tick();
        end
        bus.int_req = 1'b0;

        // Idle grant write
        for (int i = 0; i < 10; i++) cyc();
        wr0 = wr_seen;
        int_set(1'b1, 8'h12, 8'h5A);
        probe();
        chk("idle_req_cycle_addr", bus.reg_address, 8'h00);
        tick();
        probe();
        chk("idle_addr_phase", bus.reg_address, 8'h12);
        chk1("idle_addr_nowrite", bus.reg_write, 1'b0);
        tick();
        probe();
        chk1("idle_write_strobe", bus.reg_write, 1'b1);
        chk("idle_write_addr", bus.reg_address, 8'h12);
        chk("idle_write_data", bus.reg_datao, 8'h5A);
        tick();
        probe();
        chk1("idle_ack", bus.int_ack, 1'b1);
        tick();
        bus.int_req = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("idle_one_write", 8'(wr_seen - wr0), 8'd1);

        // Internal read
        int_set(1'b0, 8'h34, 8'h00);
        cyc();
        cyc();
        probe();
        chk1("rd_strobe", bus.reg_read, 1'b1);
        chk("rd_addr", bus.reg_address, 8'h34);
        tick();
        bus.reg_datai = 8'hC3;
        probe();
        chk1("rd_ack", bus.int_ack, 1'b1);
        chk("rd_data", bus.int_rdata, 8'hC3);
        tick();
        bus.int_req = 1'b0;
        bus.reg_datai = 8'h11;
        probe();
        chk("rd_data_held", bus.int_rdata, 8'hC3);
        chk1("rd_ack_single", bus.int_ack, 1'b0);
        tick();

        // Abort: busy rises in ADDR
        wr0 = wr_seen;
        int_set(1'b1, 8'h40, 8'h99);
        cyc();
        bus.usb_busy = 1'b1;
        probe();
        chk("abort_addr_phase", bus.reg_address, 8'h40);
        chk1("abort_addr_nowrite", bus.reg_write, 1'b0);
        tick();
        probe();
        chk("abort_cnt_one", bus.abort_cnt, 8'd1);
        chk1("abort_no_ack", bus.int_ack, 1'b0);
        chk1("abort_no_strobe", bus.reg_write, 1'b0);
        tick();
        cyc();
        bus.usb_busy = 1'b0;
        n = 0;
        d_ack = 1'b0;
        while (!d_ack && n < 20) begin
            cyc();
            n++;
        end
        chk1("abort_retry_ack", d_ack, 1'b1);
        bus.int_req = 1'b0;
        cyc();
        chk("abort_no_dup", 8'(wr_seen - wr0), 8'd1);
        chk("abort_cnt_kept", bus.abort_cnt, 8'd1);

        // Collision: USB write in STROBE
        for (int i = 0; i < 5; i++) cyc();
        int_set(1'b1, 8'h50, 8'h66);
        cyc();
        cyc();
        bus.usb_write = 1'b1;
        bus.usb_address = 8'hA5;
        bus.usb_datao = 8'h3C;
        probe();
        chk("coll_usb_addr", bus.reg_address, 8'hA5);
        chk("coll_usb_data", bus.reg_datao, 8'h3C);
        chk1("coll_usb_write", bus.reg_write, 1'b1);
        chk1("coll_no_read", bus.reg_read, 1'b0);
        tick();
        usb_idle();
        probe();
        chk1("coll_flag", bus.collision, 1'b1);
        chk1("coll_no_ack", bus.int_ack, 1'b0);
        chk("coll_abort_cnt", bus.abort_cnt, 8'd2);
        tick();
        bus.collision_clr = 1'b1;
        cyc();
        bus.collision_clr = 1'b0;
        probe();
        chk1("coll_cleared", bus.collision, 1'b0);
        tick();
        n = 0;
        d_ack = 1'b0;
        while (!d_ack && n < 10) begin
            cyc();
            n++;
        end
        chk1("coll_retry_ack", d_ack, 1'b1);
        bus.int_req = 1'b0;
        cyc();

        // Reset asserted during STROBE
        for (int i = 0; i < 5; i++) cyc();
        int_set(1'b1, 8'h60, 8'h24);
        cyc();
        cyc();
        probe();
        chk1("rstmid_strobe", bus.reg_write, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_addr", bus.reg_address, 8'h00);
        chk("rstmid_datao", bus.reg_datao, 8'h00);
        chk1("rstmid_write", bus.reg_write, 1'b0);
        chk1("rstmid_ack", bus.int_ack, 1'b0);
        chk("rstmid_abort", bus.abort_cnt, 8'h00);
        chk("rstmid_rdata", bus.int_rdata, 8'h00);
        tick();
        probe();
        chk1("rstmid_no_ack", bus.int_ack, 1'b0);
        tick();
        reset_n = 1'b1;

        // Random traffic against the model
        age = 0;
        busy_left = 0;
        for (int c = 0; c < 3000; c++) begin
            bit s;
            if (busy_left > 0) begin
                bus.usb_busy = 1'b1;
                busy_left--;
            end else if ($urandom % 8 == 0) begin
                bus.usb_busy = 1'b1;
                busy_left = $urandom_range(1, 10);
            end else bus.usb_busy = 1'b0;
            age = bus.usb_busy ? age + 1 : 0;
            s = (age >= 3 && $urandom % 3 == 0) || ($urandom % 64 == 0);
            bus.usb_read = s && ($urandom % 2 == 1);
            bus.usb_write = s && !bus.usb_read;
            bus.usb_hold = ($urandom % 32 == 0);
            bus.usb_address = 8'($urandom);
            bus.usb_bytecnt = 7'($urandom);
            bus.usb_datao = 8'($urandom);
            bus.reg_datai = 8'($urandom);
            bus.collision_clr = ($urandom % 16 == 0);
            if (bus.int_req && d_ack) bus.int_req = 1'b0;
            else if (!bus.int_req && $urandom % 4 == 0) begin
                bus.int_req = 1'b1;
                bus.int_we = ($urandom % 2 == 1);
                bus.int_address = 8'($urandom);
                bus.int_bytecnt = 7'($urandom);
                bus.int_wdata = 8'($urandom);
            end
            reset_n = ($urandom % 600 != 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
